// File: rtl/dense_deserial_pkg.sv
// -----------------------------------------------------------------------------
// dense_deserial_pkg
//   Shared definitions for the dense-layer frame stream:
//     DENSE1_N   words per layer-1 output frame
//     DATA_W     serial word width
//     state_e    receiver state encoding (ST_IDLE / ST_COLLECT)
//     word_lsb() LSB position of word k inside a flat N*W sum-bus vector.
//                The serializer uses the same mapping, so word 0 sits in
//                the least significant slice.
// -----------------------------------------------------------------------------
package dense_deserial_pkg;

  localparam int DENSE1_N = 120;
  localparam int DATA_W   = 16;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_e;

  // Word k occupies bits [k*w + w-1 : k*w] of the flat vector.
  function automatic int word_lsb(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/dense_deserial_if.sv
// -----------------------------------------------------------------------------
// dense_deserial_if
//   Serial word stream coming out of the dense-layer post-processing
//   (bias add + activation).
//     valid        word on data_in is present this cycle
//     frame_start  first word of a frame (only meaningful with valid)
//     frame_end    last word of a frame (only meaningful with valid)
//     data_in      signed W-bit word
//   master: the producer side; slave: the receiver side.
// -----------------------------------------------------------------------------
interface dense_deserial_if
  import dense_deserial_pkg::*;
#(
  parameter int W = DATA_W
) ();

  logic                valid;
  logic                frame_start;
  logic                frame_end;
  logic signed [W-1:0] data_in;

  modport master (
    output valid,
    output frame_start,
    output frame_end,
    output data_in
  );

  modport slave (
    input valid,
    input frame_start,
    input frame_end,
    input data_in
  );

endinterface

// File: rtl/dense_deserial.sv
// -----------------------------------------------------------------------------
// dense_deserial
//   Receives the serial dense-layer output stream and packs exactly N words
//   into one parallel vector laid out like the MAC-array sum bus. Frames that
//   are short, long or restarted are discarded and flagged.
//
//   Ports
//     clk          system clock, rising edge
//     rst_n        asynchronous active-low reset
//     ena_i        clock enable; low freezes the capture state
//     s_i          serial stream (valid / frame_start / frame_end / data_in)
//     par_data_o   last good frame, word k at bits [k*W+W-1 : k*W]
//     par_valid_o  one-cycle pulse: par_data_o just took a good frame
//     frame_err_o  one-cycle pulse: a frame was discarded
//     busy_o       high while a frame is being collected
//
//   The collect buffer is separate from par_data_o, so a frame in progress
//   never disturbs the last good frame. Words are written by index (cnt) so
//   word 0 always lands in the LSB slice.
// -----------------------------------------------------------------------------
module dense_deserial
  import dense_deserial_pkg::*;
#(
  parameter int N = DENSE1_N,
  parameter int W = DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena_i,
  dense_deserial_if.slave  s_i,
  output logic [N*W-1:0]   par_data_o,
  output logic             par_valid_o,
  output logic             frame_err_o,
  output logic             busy_o
);

  localparam int           CW     = $clog2(N + 1);
  localparam int           IW     = (N * W > 1) ? $clog2(N * W) : 1;
  localparam logic [CW:0]  N_EXT  = (CW + 1)'(N);
  localparam bit           SINGLE = (N == 1);

  // Control state
  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            par_valid_q;
  logic            frame_err_q;
  logic [N*W-1:0]  par_data_q;

  // Collect buffer (data only, never reset)
  logic [N*W-1:0]  buf_q, buf_d;

  // Per-cycle decisions
  logic            acc;
  logic            wr_en;
  logic [CW-1:0]   wr_idx;
  logic [IW-1:0]   wr_base;
  logic            good;
  logic            bad;
  logic [CW:0]     cnt_inc;
  logic            at_full;

  assign acc     = ena_i & s_i.valid;
  assign cnt_inc = {1'b0, cnt_q} + {{CW{1'b0}}, 1'b1};
  assign at_full = ({1'b0, cnt_q} == N_EXT);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else if (ena_i) begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        // A start word that is also the end word finishes immediately.
        if (acc && s_i.frame_start && !s_i.frame_end) begin
          state_d = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (acc) begin
          if (s_i.frame_start) begin
            state_d = s_i.frame_end ? ST_IDLE : ST_COLLECT;
          end else if (s_i.frame_end) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output / datapath control
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = cnt_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    good   = 1'b0;
    bad    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Words outside a frame are dropped silently.
        if (acc && s_i.frame_start) begin
          wr_en  = 1'b1;
          wr_idx = '0;
          cnt_d  = CW'(1);
          ovf_d  = 1'b0;
          if (s_i.frame_end) begin
            cnt_d = '0;
            good  = SINGLE;
            bad   = !SINGLE;
          end
        end
      end
      ST_COLLECT: begin
        if (acc) begin
          if (s_i.frame_start) begin
            // Restart: the aborted frame is reported, the word becomes word 0.
            // A restart word that also carries frame_end is treated as part of
            // the fault and only reported, so the two pulses never coincide.
            bad    = 1'b1;
            wr_en  = 1'b1;
            wr_idx = '0;
            cnt_d  = s_i.frame_end ? '0 : CW'(1);
            ovf_d  = 1'b0;
          end else if (s_i.frame_end) begin
            wr_en = !at_full;
            cnt_d = '0;
            ovf_d = 1'b0;
            if (!ovf_q && (cnt_inc == N_EXT)) begin
              good = 1'b1;
            end else begin
              bad = 1'b1;
            end
          end else if (at_full) begin
            // Extra word beyond N: drop it and remember the frame is too long.
            ovf_d = 1'b1;
          end else begin
            wr_en = 1'b1;
            cnt_d = cnt_inc[CW-1:0];
          end
        end
      end
      default: ;
    endcase
  end

  // Buffer with the current word merged in, so the final word of a frame is
  // captured into par_data on the same edge that accepts it.
  assign wr_base = IW'(word_lsb(int'(wr_idx), W));

  always_comb begin
    buf_d = buf_q;
    if (wr_en) begin
      buf_d[wr_base +: W] = s_i.data_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers: control, pulses and output frame
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      par_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      par_data_q  <= '0;
    end else begin
      if (ena_i) begin
        cnt_q <= cnt_d;
        ovf_q <= ovf_d;
      end
      // good/bad are already gated by ena through acc, so pulses self-clear.
      par_valid_q <= good;
      frame_err_q <= bad;
      if (good) begin
        par_data_q <= buf_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Collect buffer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign par_data_o  = par_data_q;
  assign par_valid_o = par_valid_q;
  assign frame_err_o = frame_err_q;
  assign busy_o      = (state_q == ST_COLLECT);

endmodule
